// File: rtl/sound_pkg.sv
// Shared sound codes, scheduler state encoding and code/duration helpers.
package sound_pkg;

  localparam logic [3:0] SND_NONE   = 4'd0;
  localparam logic [3:0] SND_WALL   = 4'd1;
  localparam logic [3:0] SND_PLATE  = 4'd2;
  localparam logic [3:0] SND_BRICK  = 4'd3;
  localparam logic [3:0] SND_GROUND = 4'd4;

  // Pending vector bit order: [0] wall, [1] plate, [2] brick, [3] ground
  localparam int unsigned NUM_EVT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    PLAY,
    GAP
  } state_t;

  // Fixed priority: ground > plate > brick > wall
  function automatic logic [3:0] pick_code(input logic [NUM_EVT-1:0] pend);
    logic [3:0] c;
    if (pend[3])      c = SND_GROUND;
    else if (pend[1]) c = SND_PLATE;
    else if (pend[2]) c = SND_BRICK;
    else if (pend[0]) c = SND_WALL;
    else              c = SND_NONE;
    return c;
  endfunction

  function automatic logic [NUM_EVT-1:0] code_onehot(input logic [3:0] code);
    logic [NUM_EVT-1:0] m;
    case (code)
      SND_WALL:   m = 4'b0001;
      SND_PLATE:  m = 4'b0010;
      SND_BRICK:  m = 4'b0100;
      SND_GROUND: m = 4'b1000;
      default:    m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic int unsigned code_duration(input logic [3:0] code,
                                                input int unsigned dw,
                                                input int unsigned dp,
                                                input int unsigned db,
                                                input int unsigned dg);
    int unsigned d;
    case (code)
      SND_WALL:   d = dw;
      SND_PLATE:  d = dp;
      SND_BRICK:  d = db;
      SND_GROUND: d = dg;
      default:    d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sound_event_latch.sv
// Edge-detects the hit inputs, holds pending requests, flags coalesced events.
module sound_event_latch
  import sound_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] hit,
  input  logic               mute,
  input  logic [NUM_EVT-1:0] clr,
  output logic [NUM_EVT-1:0] pending,
  output logic               dropped
);

  logic [NUM_EVT-1:0] hit_q;
  logic               armed;
  logic [NUM_EVT-1:0] rise;

  // The first edge after reset only samples, so a level already high at
  // release is not taken as a new event.
  always_comb begin
    rise = '0;
    if (armed) rise = hit & ~hit_q;
  end

  // Pending bits: set wins over clear; a rise on a bit that stays pending is a drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q   <= '0;
      armed   <= 1'b0;
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      hit_q <= hit;
      armed <= 1'b1;
      if (mute) begin
        pending <= '0;
        dropped <= 1'b0;
      end else begin
        pending <= (pending & ~clr) | rise;
        dropped <= |(rise & pending & ~clr);
      end
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates pending game sounds and hands them to the tone player with
// play-duration and silence-gap timing.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned DUR_WALL   = 8,
  parameter int unsigned DUR_PLATE  = 12,
  parameter int unsigned DUR_BRICK  = 6,
  parameter int unsigned DUR_GROUND = 32,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Hit_wall,
  input  logic       Hit_plate,
  input  logic       Hit_brick,
  input  logic       Hit_ground,
  input  logic       Mute,
  input  logic       Data_request,
  output logic       Data_ready,
  output logic [3:0] sound_code,
  output logic       Playing,
  output logic       Dropped
);

  state_t             state;
  logic [3:0]         code_q;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_EVT-1:0] pending;
  logic [NUM_EVT-1:0] clr;
  logic [3:0]         issue_code;
  logic               preempt;
  int unsigned        dur_full;
  logic [CNT_W-1:0]   dur_trunc;
  logic [CNT_W-1:0]   dur_load;
  logic [CNT_W-1:0]   gap_trunc;
  logic [CNT_W-1:0]   gap_load;

  sound_event_latch u_latch (
    .clk     (clk),
    .reset   (reset),
    .hit     ({Hit_ground, Hit_brick, Hit_plate, Hit_wall}),
    .mute    (Mute),
    .clr     (clr),
    .pending (pending),
    .dropped (Dropped)
  );

  // Pick the next code and clear its pending bit on the same edge it is latched.
  always_comb begin
    issue_code = pick_code(pending);
    preempt    = (state == PLAY) && pending[3] && (code_q != SND_GROUND);
    clr        = '0;
    if (!Mute) begin
      if (state == IDLE && (|pending)) clr = code_onehot(issue_code);
      else if (preempt)                clr = code_onehot(SND_GROUND);
    end
  end

  // Counter reload values; the counter runs N-1..0, and zero lengths behave as one.
  always_comb begin
    dur_full  = code_duration(code_q, DUR_WALL, DUR_PLATE, DUR_BRICK, DUR_GROUND);
    dur_trunc = CNT_W'(dur_full);
    dur_load  = (dur_trunc == '0) ? '0 : dur_trunc - CNT_W'(1);
    gap_trunc = CNT_W'(GAP_CYCLES);
    gap_load  = (gap_trunc == '0) ? '0 : gap_trunc - CNT_W'(1);
  end

  // Scheduler FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      code_q     <= SND_NONE;
      cnt        <= '0;
      Data_ready <= 1'b0;
      sound_code <= SND_NONE;
      Playing    <= 1'b0;
    end else if (Mute) begin
      state      <= IDLE;
      code_q     <= SND_NONE;
      cnt        <= '0;
      Data_ready <= 1'b0;
      sound_code <= SND_NONE;
      Playing    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sound_code <= SND_NONE;
          if (|pending) begin
            code_q     <= issue_code;
            sound_code <= issue_code;
            Data_ready <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (Data_request) begin
            Data_ready <= 1'b0;
            Playing    <= 1'b1;
            cnt        <= dur_load;
            state      <= PLAY;
          end
        end
        PLAY: begin
          if (preempt) begin
            code_q     <= SND_GROUND;
            sound_code <= SND_GROUND;
            Data_ready <= 1'b1;
            Playing    <= 1'b0;
            state      <= ISSUE;
          end else if (cnt == '0) begin
            Playing    <= 1'b0;
            sound_code <= SND_NONE;
            cnt        <= gap_load;
            state      <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            code_q <= SND_NONE;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Durations must fit the counter; wider values would be silently truncated.
  a_dur_fits: assert property (@(posedge clk) disable iff (!reset)
    (state == ISSUE && Data_request && !Mute) |-> (64'(dur_full) < (64'd1 << CNT_W)));
  a_gap_fits: assert property (@(posedge clk) disable iff (!reset)
    (state == PLAY) |-> (64'(GAP_CYCLES) < (64'd1 << CNT_W)));

endmodule

// File: tb/tb_sound_scheduler.sv
// Randomised and directed bench for sound_scheduler with a cycle-stepped
// reference model and an issue-order scoreboard.
module tb_sound_scheduler;

  localparam int unsigned DW   = 8;
  localparam int unsigned DP   = 12;
  localparam int unsigned DB   = 6;
  localparam int unsigned DG   = 32;
  localparam int unsigned GAPC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hw = 1'b0, hp = 1'b0, hb = 1'b0, hg = 1'b0;
  logic       mute = 1'b0, req = 1'b0;
  logic       Data_ready, Playing, Dropped;
  logic [3:0] sound_code;

  int tests = 0;
  int fails = 0;

  sound_scheduler #(
    .DUR_WALL   (DW),
    .DUR_PLATE  (DP),
    .DUR_BRICK  (DB),
    .DUR_GROUND (DG),
    .GAP_CYCLES (GAPC),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Hit_wall     (hw),
    .Hit_plate    (hp),
    .Hit_brick    (hb),
    .Hit_ground   (hg),
    .Mute         (mute),
    .Data_request (req),
    .Data_ready   (Data_ready),
    .sound_code   (sound_code),
    .Playing      (Playing),
    .Dropped      (Dropped)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Events indexed by their sound code (1 wall .. 4 ground).
  bit m_pend[1:4];
  bit m_prev[1:4];
  bit m_rise[1:4];
  bit m_hits[1:4];
  bit m_armed   = 1'b0;
  bit m_issuing = 1'b0;
  int m_play    = 0;
  int m_gap     = 0;
  int m_cur     = 0;
  int m_taken   = 0;
  bit e_ready   = 1'b0;
  bit e_play    = 1'b0;
  bit e_drop    = 1'b0;
  int e_code    = 0;
  int exp_q[$];

  function automatic int dur_of(int c);
    int d;
    case (c)
      1: d = DW;
      2: d = DP;
      3: d = DB;
      4: d = DG;
      default: d = 0;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int best_pending();
    if (m_pend[4]) return 4;
    if (m_pend[2]) return 2;
    if (m_pend[3]) return 3;
    if (m_pend[1]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 1; c <= 4; c++) begin
        m_pend[c] = 1'b0;
        m_prev[c] = 1'b0;
      end
      m_armed = 1'b0; m_issuing = 1'b0; m_play = 0; m_gap = 0; m_cur = 0;
      e_drop = 1'b0;
      exp_q.delete();
    end else begin
      m_hits[1] = hw; m_hits[2] = hp; m_hits[3] = hb; m_hits[4] = hg;
      for (int c = 1; c <= 4; c++) begin
        m_rise[c] = m_armed && m_hits[c] && !m_prev[c];
        m_prev[c] = m_hits[c];
      end
      m_armed = 1'b1;
      if (mute) begin
        for (int c = 1; c <= 4; c++) m_pend[c] = 1'b0;
        m_issuing = 1'b0; m_play = 0; m_gap = 0; m_cur = 0;
        e_drop = 1'b0;
      end else begin
        m_taken = 0;
        if (m_issuing) begin
          if (req) begin
            m_issuing = 1'b0;
            m_play = dur_of(m_cur);
            exp_q.push_back(m_cur);
          end
        end else if (m_play > 0) begin
          if (m_pend[4] && m_cur != 4) begin
            m_cur = 4; m_taken = 4; m_issuing = 1'b1; m_play = 0;
          end else begin
            m_play--;
            if (m_play == 0) m_gap = (GAPC == 0) ? 1 : GAPC;
          end
        end else if (m_gap > 0) begin
          m_gap--;
        end else begin
          m_taken = best_pending();
          if (m_taken != 0) begin
            m_cur = m_taken;
            m_issuing = 1'b1;
          end
        end
        e_drop = 1'b0;
        for (int c = 1; c <= 4; c++)
          if (m_rise[c] && m_pend[c] && c != m_taken) e_drop = 1'b1;
        for (int c = 1; c <= 4; c++) begin
          if (c == m_taken) m_pend[c] = 1'b0;
          if (m_rise[c]) m_pend[c] = 1'b1;
        end
      end
    end
    e_ready = m_issuing;
    e_play  = (m_play > 0);
    e_code  = (m_issuing || m_play > 0) ? m_cur : 0;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  bit last_play = 1'b0;
  int got_code;

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_ready", int'(Data_ready), 0);
      check("reset_code", int'(sound_code), 0);
      check("reset_playing", int'(Playing), 0);
      check("reset_dropped", int'(Dropped), 0);
      last_play = 1'b0;
    end else begin
      check("ready", int'(Data_ready), int'(e_ready));
      check("code", int'(sound_code), e_code);
      check("playing", int'(Playing), int'(e_play));
      check("dropped", int'(Dropped), int'(e_drop));
      if (Playing && !last_play) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_play", int'(sound_code), 0);
        end else begin
          got_code = exp_q.pop_front();
          check("sb_issue_order", int'(sound_code), got_code);
        end
      end
      last_play = Playing;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit w, input bit p, input bit b, input bit g);
    hw = w; hp = p; hb = b; hg = g;
    step(1);
    hw = 1'b0; hp = 1'b0; hb = 1'b0; hg = 1'b0;
  endtask

  int mute_left  = 0;
  int reset_left = 0;

  initial begin
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);

    // single wall sound, request always granted
    req = 1'b1;
    pulse(1, 0, 0, 0);
    step(20);

    // simultaneous wall, plate, ground: ordered by priority
    pulse(1, 1, 0, 1);
    step(100);

    // brick re-triggered while still pending and not yet accepted
    req = 1'b0;
    pulse(0, 0, 1, 0);
    step(2);
    pulse(0, 0, 1, 0);
    step(2);
    pulse(0, 0, 1, 0);
    step(3);
    req = 1'b1;
    step(15);

    // ground preempts plate mid-play
    pulse(0, 1, 0, 0);
    step(8);
    pulse(0, 0, 0, 1);
    step(50);

    // long stall in the handshake
    req = 1'b0;
    pulse(1, 0, 0, 0);
    step(20);
    req = 1'b1;
    step(15);

    // mute during play, events while muted are ignored
    pulse(0, 0, 0, 1);
    step(10);
    mute = 1'b1;
    step(3);
    pulse(1, 0, 1, 0);
    step(3);
    mute = 1'b0;
    step(5);

    // reset during issue, brick level held across release
    req = 1'b0;
    pulse(0, 1, 0, 0);
    step(3);
    hb = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    hb = 1'b0;
    req = 1'b1;
    step(10);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      hw = ($urandom_range(0, 24) == 0);
      hp = ($urandom_range(0, 24) == 0);
      hb = ($urandom_range(0, 24) == 0);
      hg = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 3) != 0);
      if (mute_left > 0) mute_left--;
      else if ($urandom_range(0, 299) == 0) mute_left = $urandom_range(1, 5);
      mute = (mute_left > 0);
      if (reset_left > 0) reset_left--;
      else if ($urandom_range(0, 999) == 0) reset_left = 2;
      reset = (reset_left == 0);
      step(1);
    end

    // drain
    hw = 1'b0; hp = 1'b0; hb = 1'b0; hg = 1'b0;
    mute = 1'b0; reset = 1'b1; req = 1'b1;
    step(150);
    check("sb_drained", exp_q.size(), 0);
    check("final_idle_code", int'(sound_code), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
